// File: rtl/data_gen_sched.sv
// Round-robin scheduler sharing one data_gen generator among NREQ requesters.
// Optional busy-cycle statistics counter is built when DATA_GEN_SCHED_STATS_EN is defined.
module data_gen_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_size,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      req_done,
  output logic                 gen_start,
  output logic [31:0]          gen_size,
  input  logic                 gen_ready,
  input  logic                 gen_done,
  input  logic                 gen_idle,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id,
  output logic [31:0]          run_count,
  output logic [31:0]          busy_cycles,
  output logic [1:0]           dbg_state_o
);

  // Handshakes: a requester holds req_valid/req_size until the cycle req_ready[i]
  // is high (accept); gen_start is held until the cycle gen_ready is high.
  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_id_q, last_id_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [31:0]     gen_size_q, gen_size_d;
  logic [31:0]     run_count_q, run_count_d;

  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [31:0]     win_size;
  int              cand;

  // Search starts one past the last served requester so every waiter gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_id_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
    win_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == ID_W'(i)) win_size = req_size[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    last_id_d   = last_id_q;
    cur_id_d    = cur_id_q;
    gen_size_d  = gen_size_q;
    run_count_d = run_count_q;
    req_ready   = '0;
    req_done    = '0;
    gen_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && gen_idle) begin
          for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) req_ready[i] = 1'b1;
          end
          cur_id_d   = win_id;
          gen_size_d = win_size;
          // The generator hangs on size 0, so such requests skip straight to RESP.
          state_d    = (win_size != 32'd0) ? START : RESP;
        end
      end
      START: begin
        gen_start = 1'b1;
        if (gen_ready) state_d = RUN;
      end
      RUN: begin
        if (gen_done) begin
          state_d     = RESP;
          run_count_d = run_count_q + 32'd1;
        end
      end
      RESP: begin
        for (int i = 0; i < NREQ; i++) begin
          if (cur_id_q == ID_W'(i)) req_done[i] = 1'b1;
        end
        last_id_d = cur_id_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      last_id_q   <= ID_W'(NREQ - 1);
      cur_id_q    <= '0;
      gen_size_q  <= '0;
      run_count_q <= '0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      cur_id_q    <= cur_id_d;
      gen_size_q  <= gen_size_d;
      run_count_q <= run_count_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign cur_id      = cur_id_q;
  assign gen_size    = gen_size_q;
  assign run_count   = run_count_q;
  assign dbg_state_o = state_q;

`ifdef DATA_GEN_SCHED_STATS_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (busy && busy_cycles_q != 32'hFFFF_FFFF) busy_cycles_d = busy_cycles_q + 32'd1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) busy_cycles_q <= '0;
    else           busy_cycles_q <= busy_cycles_d;
  end

  assign busy_cycles = busy_cycles_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_data_gen_sched.sv
// Directed bench for data_gen_sched with a small behavioural generator model.
// Busy-cycle expectations follow DATA_GEN_SCHED_STATS_EN when defined.
module tb_data_gen_sched;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [32*NREQ-1:0] req_size = '0;
  logic [NREQ-1:0]   req_ready, req_done;
  logic              gen_start;
  logic [31:0]       gen_size;
  logic              gen_ready, gen_done, gen_idle;
  logic              busy;
  logic [ID_W-1:0]   cur_id;
  logic [31:0]       run_count, busy_cycles;
  logic [1:0]        dbg_state;

  // Generator stand-in: automatic model, or manual pins for corner cases.
  logic        man_mode = 1'b0;
  logic        man_ready = 1'b0, man_done = 1'b0, man_idle = 1'b1;
  logic        g_busy;
  logic [31:0] g_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_run = 0;
  int exp_busy = 0;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] size;
    int          exp_w;
    int          exp_lat;
  } vec_t;
  vec_t tbl[10];

  logic [3:0] grant_q[$];
  logic [3:0] exp_q[$];

  data_gen_sched #(.NREQ(NREQ)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_size(req_size),
    .req_ready(req_ready), .req_done(req_done),
    .gen_start(gen_start), .gen_size(gen_size),
    .gen_ready(gen_ready), .gen_done(gen_done), .gen_idle(gen_idle),
    .busy(busy), .cur_id(cur_id), .run_count(run_count),
    .busy_cycles(busy_cycles), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  assign gen_idle  = man_mode ? man_idle  : !g_busy;
  assign gen_ready = man_mode ? man_ready : (gen_start && !g_busy);
  assign gen_done  = man_mode ? man_done  : (g_busy && g_cnt == 32'd1);

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      g_busy <= 1'b0;
      g_cnt  <= '0;
    end else if (!man_mode && !g_busy && gen_start) begin
      g_busy <= 1'b1;
      g_cnt  <= gen_size;
    end else if (g_busy) begin
      g_cnt <= g_cnt - 32'd1;
      if (g_cnt == 32'd1) g_busy <= 1'b0;
    end
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_bc(input int v);
`ifdef DATA_GEN_SCHED_STATS_EN
    return 32'(v);
`else
    return 32'd0 + 32'(v * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    man_mode  = 1'b0;
    man_ready = 1'b0;
    man_done  = 1'b0;
    man_idle  = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    exp_run  = 0;
    exp_busy = 0;
  endtask

  // One request from grant to completion; called at posedge+1 and returns there.
  task automatic run_entry(input logic [3:0] mask, input logic [31:0] size,
                           input int w, input int lat);
    bit got, gotd;
    int gcyc, dcyc, starts, beats;
    logic [3:0] act;
    req_valid = mask;
    req_size  = {4{size}};
    got = 0;
    act = '0;
    gcyc = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge ap_clk);
      if (req_ready != '0) begin
        got = 1; gcyc = cyc; act = req_ready;
      end else tick();
    end
    if (!got) begin
      chk("grant_timeout", 32'd0, 32'd1);
      req_valid = '0;
      tick();
      return;
    end
    chk("grant_onehot", 32'(act), 32'(4'b0001 << w));
    tick();
    req_valid = '0;
    @(negedge ap_clk);
    chk("cur_id", 32'(cur_id), 32'(w));
    chk("gen_size", gen_size, size);
    starts = 0; beats = 0; gotd = 0; dcyc = 0; act = '0;
    for (int k = 0; k < 300 && !gotd; k++) begin
      if (k > 0) begin
        tick();
        @(negedge ap_clk);
      end
      starts += int'(gen_start);
      beats  += int'(g_busy);
      if (req_done != '0) begin
        gotd = 1; dcyc = cyc; act = req_done;
      end
    end
    if (!gotd) chk("done_timeout", 32'd0, 32'd1);
    chk("done_onehot", 32'(act), 32'(4'b0001 << w));
    chk("done_latency", 32'(dcyc - gcyc), 32'(lat));
    chk("start_cycles", 32'(starts), (size == 0) ? 32'd0 : 32'd1);
    chk("beats", 32'(beats), size);
    if (size != 0) exp_run++;
    exp_busy += lat;
    tick();
    @(negedge ap_clk);
    chk("run_count", run_count, 32'(exp_run));
    chk("busy_after", 32'(busy), 32'd0);
    chk("busy_cycles", busy_cycles, exp_bc(exp_busy));
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nd;
    logic [3:0] clr, e;

    tbl[0] = '{4'b0001, 32'd16, 0, 18};
    tbl[1] = '{4'b0101, 32'd3,  2, 5};
    tbl[2] = '{4'b0101, 32'd2,  0, 4};
    tbl[3] = '{4'b0101, 32'd5,  2, 7};
    tbl[4] = '{4'b0111, 32'd1,  0, 3};
    tbl[5] = '{4'b0111, 32'd2,  1, 4};
    tbl[6] = '{4'b0010, 32'd0,  1, 1};
    tbl[7] = '{4'b1001, 32'd4,  3, 6};
    tbl[8] = '{4'b1001, 32'd1,  0, 3};
    tbl[9] = '{4'b1000, 32'd0,  3, 1};

    // Reset values
    do_reset();
    @(negedge ap_clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_req_done", 32'(req_done), 32'd0);
    chk("rst_gen_start", 32'(gen_start), 32'd0);
    chk("rst_gen_size", gen_size, 32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_run_count", run_count, 32'd0);
    chk("rst_busy_cycles", busy_cycles, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    tick();

    // Table: single request, fairness, zero size, withdrawal
    for (int i = 0; i < 10; i++) run_entry(tbl[i].mask, tbl[i].size, tbl[i].exp_w, tbl[i].exp_lat);

    // All four requesters held valid: grants and completions in order 0..3
    do_reset();
    grant_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back(4'b0001 << i);
      exp_q.push_back(4'b0001 << i);
    end
    req_size  = {32'd4, 32'd3, 32'd2, 32'd1};
    req_valid = 4'hF;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
      @(negedge ap_clk);
      clr = '0;
      if (req_ready != '0) begin
        e = (grant_q.size() > 0) ? grant_q.pop_front() : 4'b0000;
        chk("all_grant", 32'(req_ready), 32'(e));
        clr = req_ready;
      end
      if (req_done != '0) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        chk("all_done", 32'(req_done), 32'(e));
      end
      tick();
      req_valid = req_valid & ~clr;
    end
    chk("all_pending", 32'(exp_q.size()), 32'd0);
    @(negedge ap_clk);
    chk("all_run_count", run_count, 32'd4);
    tick();

    // Manual generator: gen_idle gating, spurious gen_done, held gen_start
    do_reset();
    man_mode  = 1'b1;
    man_idle  = 1'b0;
    man_done  = 1'b1;
    req_valid = 4'b0001;
    req_size  = {4{32'd5}};
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("idle_block", 32'(req_ready), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'd0);
      tick();
    end
    man_done = 1'b0;
    man_idle = 1'b1;
    @(negedge ap_clk);
    chk("idle_spurious_run", run_count, 32'd0);
    chk("grant_when_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    man_done  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge ap_clk);
      chk("start_hold_state", 32'(dbg_state), 32'd1);
      chk("start_hold", 32'(gen_start), 32'd1);
      tick();
    end
    man_done  = 1'b0;
    man_ready = 1'b1;
    @(negedge ap_clk);
    chk("start_ready_state", 32'(dbg_state), 32'd1);
    tick();
    man_ready = 1'b0;
    @(negedge ap_clk);
    chk("run_state", 32'(dbg_state), 32'd2);
    chk("run_no_start", 32'(gen_start), 32'd0);
    chk("start_spurious_run", run_count, 32'd0);
    tick();
    man_done = 1'b1;
    @(negedge ap_clk);
    chk("run_no_done_yet", 32'(req_done), 32'd0);
    tick();
    man_done = 1'b0;
    @(negedge ap_clk);
    chk("resp_done", 32'(req_done), 32'd1);
    chk("resp_state", 32'(dbg_state), 32'd3);
    chk("resp_run_count", run_count, 32'd1);
    tick();
    @(negedge ap_clk);
    chk("back_idle", 32'(busy), 32'd0);
    tick();
    man_mode = 1'b0;

    // Reset during RUN, then normal service starting from requester 0
    do_reset();
    req_valid = 4'b0100;
    req_size  = {4{32'd20}};
    @(negedge ap_clk);
    chk("d_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    repeat (4) tick();
    @(negedge ap_clk);
    chk("d_in_run", 32'(dbg_state), 32'd2);
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_gen_start", 32'(gen_start), 32'd0);
    chk("mid_rst_gen_size", gen_size, 32'd0);
    chk("mid_rst_cur_id", 32'(cur_id), 32'd0);
    chk("mid_rst_req_done", 32'(req_done), 32'd0);
    chk("mid_rst_run_count", run_count, 32'd0);
    chk("mid_rst_busy_cycles", busy_cycles, 32'd0);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    exp_run  = 0;
    exp_busy = 0;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge ap_clk);
      if (req_done != '0) nd++;
      tick();
    end
    chk("no_done_after_abort", 32'(nd), 32'd0);
    run_entry(4'b0101, 32'd2, 0, 4);

    // Statistics: one size-8 run keeps busy high for 10 cycles
    do_reset();
    run_entry(4'b0001, 32'd8, 0, 10);
    @(negedge ap_clk);
    chk("stats_size8", busy_cycles, exp_bc(10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
